// File: rtl/int_to_fp_pipe.sv
// int_to_fp_pipe: 3-stage integer (32/64-bit, signed/unsigned) to FP32/FP64 converter with valid/ready flow.
// Define INT_TO_FP_FFLAGS_EN to build the inexact (NX) flag; without it out_fflags is tied to zero.

module int_to_fp_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  in_valid,
  output logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_fmt,
  input  logic                  in_signed_unsigned,
  input  logic                  in_output_fmt,
  input  logic [2:0]            in_rm,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [4:0]            out_fflags
);

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  logic                 advance;

  logic                 s1_valid_q, s1_valid_d;
  logic [63:0]          s1_mag_q, s1_mag_d;
  logic                 s1_sign_q, s1_sign_d;
  logic                 s1_ofmt_q, s1_ofmt_d;
  logic [2:0]           s1_rm_q, s1_rm_d;
  logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;

  logic                 s2_valid_q, s2_valid_d;
  logic [63:0]          s2_norm_q, s2_norm_d;
  logic [5:0]           s2_lz_q, s2_lz_d;
  logic                 s2_sign_q, s2_sign_d;
  logic                 s2_ofmt_q, s2_ofmt_d;
  logic [2:0]           s2_rm_q, s2_rm_d;
  logic [TAG_WIDTH-1:0] s2_tag_q, s2_tag_d;

  logic                 s3_valid_q, s3_valid_d;
  logic [63:0]          s3_data_q, s3_data_d;
  logic [TAG_WIDTH-1:0] s3_tag_q, s3_tag_d;

  // The whole pipe advances as one; a full output register that is not taken freezes every stage.
  assign out_ready = !s3_valid_q || in_ready;
  assign advance   = out_ready;

  assign out_valid = s3_valid_q;
  assign out_data  = s3_data_q;
  assign out_tag   = s3_tag_q;

  // ---------------------------------------------------------------- S1
  logic [63:0] op_ext;
  logic        op_neg;
  logic [63:0] op_mag;

  always_comb begin
    if (in_fmt) begin
      op_ext = in_data[63:0];
    end else if (!in_signed_unsigned) begin
      op_ext = {{32{in_data[31]}}, in_data[31:0]};
    end else begin
      op_ext = {32'd0, in_data[31:0]};
    end
    op_neg = !in_signed_unsigned && op_ext[63];
    // Two's complement of the most negative value stays 2^63, which is the correct magnitude.
    op_mag = op_neg ? (~op_ext + 64'd1) : op_ext;

    s1_valid_d = s1_valid_q;
    s1_mag_d   = s1_mag_q;
    s1_sign_d  = s1_sign_q;
    s1_ofmt_d  = s1_ofmt_q;
    s1_rm_d    = s1_rm_q;
    s1_tag_d   = s1_tag_q;
    if (advance) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_mag_d  = op_mag;
        s1_sign_d = op_neg;
        s1_ofmt_d = in_output_fmt;
        s1_rm_d   = in_rm;
        s1_tag_d  = in_tag;
      end
    end
  end

  // ---------------------------------------------------------------- S2
  logic [63:0] nrm;
  logic [5:0]  lz;

  always_comb begin
    nrm = s1_mag_q;
    lz  = 6'd0;
    if (nrm[63:32] == 32'd0) begin
      nrm   = nrm << 32;
      lz[5] = 1'b1;
    end
    if (nrm[63:48] == 16'd0) begin
      nrm   = nrm << 16;
      lz[4] = 1'b1;
    end
    if (nrm[63:56] == 8'd0) begin
      nrm   = nrm << 8;
      lz[3] = 1'b1;
    end
    if (nrm[63:60] == 4'd0) begin
      nrm   = nrm << 4;
      lz[2] = 1'b1;
    end
    if (nrm[63:62] == 2'd0) begin
      nrm   = nrm << 2;
      lz[1] = 1'b1;
    end
    if (nrm[63] == 1'b0) begin
      nrm   = nrm << 1;
      lz[0] = 1'b1;
    end

    s2_valid_d = s2_valid_q;
    s2_norm_d  = s2_norm_q;
    s2_lz_d    = s2_lz_q;
    s2_sign_d  = s2_sign_q;
    s2_ofmt_d  = s2_ofmt_q;
    s2_rm_d    = s2_rm_q;
    s2_tag_d   = s2_tag_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_norm_d = nrm;
        s2_lz_d   = lz;
        s2_sign_d = s1_sign_q;
        s2_ofmt_d = s1_ofmt_q;
        s2_rm_d   = s1_rm_q;
        s2_tag_d  = s1_tag_q;
      end
    end
  end

  // ---------------------------------------------------------------- S3
  logic        is_zero;
  logic [51:0] mant_raw;
  logic        guard_bit;
  logic        sticky_bit;
  logic        rnd_up;
  logic [52:0] mant_sum;
  logic        carry;
  logic [5:0]  msb_idx;
  logic [10:0] exp64;
  logic [7:0]  exp32;
  logic [63:0] packed_res;

  always_comb begin
    // After normalisation bit 63 is clear only for a zero operand.
    is_zero = !s2_norm_q[63];
    if (s2_ofmt_q) begin
      mant_raw   = s2_norm_q[62:11];
      guard_bit  = s2_norm_q[10];
      sticky_bit = |s2_norm_q[9:0];
    end else begin
      mant_raw   = {29'd0, s2_norm_q[62:40]};
      guard_bit  = s2_norm_q[39];
      sticky_bit = |s2_norm_q[38:0];
    end

    case (s2_rm_q)
      RM_RTZ:  rnd_up = 1'b0;
      RM_RDN:  rnd_up = s2_sign_q && (guard_bit || sticky_bit);
      RM_RUP:  rnd_up = !s2_sign_q && (guard_bit || sticky_bit);
      RM_RMM:  rnd_up = guard_bit;
      RM_RNE:  rnd_up = guard_bit && (sticky_bit || mant_raw[0]);
      default: rnd_up = guard_bit && (sticky_bit || mant_raw[0]);
    endcase

    mant_sum = {1'b0, mant_raw} + {52'd0, rnd_up};
    carry    = s2_ofmt_q ? mant_sum[52] : mant_sum[23];
    msb_idx  = 6'd63 - s2_lz_q;
    exp64    = {5'd0, msb_idx} + 11'd1023 + {10'd0, carry};
    exp32    = {2'd0, msb_idx} + 8'd127 + {7'd0, carry};

    if (s2_ofmt_q) begin
      packed_res = is_zero ? 64'd0
                           : {s2_sign_q, exp64, (carry ? 52'd0 : mant_sum[51:0])};
    end else begin
      packed_res = is_zero ? {32'hFFFF_FFFF, 32'd0}
                           : {32'hFFFF_FFFF, s2_sign_q, exp32, (carry ? 23'd0 : mant_sum[22:0])};
    end

    s3_valid_d = s3_valid_q;
    s3_data_d  = s3_data_q;
    s3_tag_d   = s3_tag_q;
    if (advance) begin
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        s3_data_d = packed_res;
        s3_tag_d  = s2_tag_q;
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mag_q   <= '0;
      s1_sign_q  <= 1'b0;
      s1_ofmt_q  <= 1'b0;
      s1_rm_q    <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_norm_q  <= '0;
      s2_lz_q    <= '0;
      s2_sign_q  <= 1'b0;
      s2_ofmt_q  <= 1'b0;
      s2_rm_q    <= '0;
      s2_tag_q   <= '0;
      s3_valid_q <= 1'b0;
      s3_data_q  <= '0;
      s3_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mag_q   <= s1_mag_d;
      s1_sign_q  <= s1_sign_d;
      s1_ofmt_q  <= s1_ofmt_d;
      s1_rm_q    <= s1_rm_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_norm_q  <= s2_norm_d;
      s2_lz_q    <= s2_lz_d;
      s2_sign_q  <= s2_sign_d;
      s2_ofmt_q  <= s2_ofmt_d;
      s2_rm_q    <= s2_rm_d;
      s2_tag_q   <= s2_tag_d;
      s3_valid_q <= s3_valid_d;
      s3_data_q  <= s3_data_d;
      s3_tag_q   <= s3_tag_d;
    end
  end

`ifdef INT_TO_FP_FFLAGS_EN
  logic s3_nx_q, s3_nx_d;

  always_comb begin
    s3_nx_d = s3_nx_q;
    if (advance && s2_valid_q) begin
      s3_nx_d = guard_bit || sticky_bit;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      s3_nx_q <= 1'b0;
    end else begin
      s3_nx_q <= s3_nx_d;
    end
  end

  assign out_fflags = {4'b0000, s3_nx_q};
`else
  assign out_fflags = 5'b00000;
`endif

endmodule

// File: tb/tb_int_to_fp_pipe.sv
// Directed bench for int_to_fp_pipe: conversion vector table, stall/ordering sequence and mid-flight reset.
// NX expectations follow the INT_TO_FP_FFLAGS_EN build option.

module tb_int_to_fp_pipe;

  localparam int TAG_WIDTH = 4;
`ifdef INT_TO_FP_FFLAGS_EN
  localparam bit NX_EN = 1'b1;
`else
  localparam bit NX_EN = 1'b0;
`endif

  logic                 in_clk;
  logic                 in_rst_n;
  logic                 in_valid;
  logic                 out_ready;
  logic [63:0]          in_data;
  logic                 in_fmt;
  logic                 in_signed_unsigned;
  logic                 in_output_fmt;
  logic [2:0]           in_rm;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 in_ready;
  logic [63:0]          out_data;
  logic [TAG_WIDTH-1:0] out_tag;
  logic [4:0]           out_fflags;

  int tests  = 0;
  int failed = 0;

  int_to_fp_pipe #(.DATA_WIDTH(64), .TAG_WIDTH(TAG_WIDTH)) dut (
    .in_clk            (in_clk),
    .in_rst_n          (in_rst_n),
    .in_valid          (in_valid),
    .out_ready         (out_ready),
    .in_data           (in_data),
    .in_fmt            (in_fmt),
    .in_signed_unsigned(in_signed_unsigned),
    .in_output_fmt     (in_output_fmt),
    .in_rm             (in_rm),
    .in_tag            (in_tag),
    .out_valid         (out_valid),
    .in_ready          (in_ready),
    .out_data          (out_data),
    .out_tag           (out_tag),
    .out_fflags        (out_fflags)
  );

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  typedef struct {
    logic [63:0] data;
    logic        fmt;
    logic        uns;
    logic        ofmt;
    logic [2:0]  rm;
    logic [63:0] exp_data;
    logic        nx;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    logic [4:0] exp_ff;
    exp_ff = (NX_EN && v.nx) ? 5'b00001 : 5'b00000;
    @(negedge in_clk);
    in_ready           = 1'b1;
    in_valid           = 1'b1;
    in_data            = v.data;
    in_fmt             = v.fmt;
    in_signed_unsigned = v.uns;
    in_output_fmt      = v.ofmt;
    in_rm              = v.rm;
    in_tag             = TAG_WIDTH'(idx);
    #1;
    chk("accept_ready", {63'd0, out_ready}, 64'd1);
    @(posedge in_clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge in_clk);
      lat++;
      if (out_valid) break;
    end
    chk("latency", 64'(lat), 64'd3);
    chk("data", out_data, v.exp_data);
    chk("tag", {60'd0, out_tag}, {60'd0, TAG_WIDTH'(idx)});
    chk("fflags", {59'd0, out_fflags}, {59'd0, exp_ff});
    $display("[TB] vec %0d in=%h fmt=%0d uns=%0d ofmt=%0d rm=%0d -> out=%h flags=%b lat=%0d",
             idx, v.data, v.fmt, v.uns, v.ofmt, v.rm, out_data, out_fflags, lat);
  endtask

  task automatic stall_seq();
    int          next_op = 1;
    int          got = 0;
    int          low_cycles = 0;
    int          extra = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic [3:0]  prev_tag = '0;
    logic [63:0] exp_fp [1:4];
    exp_fp[1] = 64'h3FF0_0000_0000_0000;
    exp_fp[2] = 64'h4000_0000_0000_0000;
    exp_fp[3] = 64'h4008_0000_0000_0000;
    exp_fp[4] = 64'h4010_0000_0000_0000;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge in_clk);
      in_ready           = (cyc >= 5);
      in_valid           = (next_op <= 4);
      in_data            = 64'(next_op);
      in_fmt             = 1'b1;
      in_signed_unsigned = 1'b1;
      in_output_fmt      = 1'b1;
      in_rm              = 3'd0;
      in_tag             = TAG_WIDTH'(next_op);
      #1;
      if (out_valid && !in_ready) begin
        chk("stall_ready", {63'd0, out_ready}, 64'd0);
        low_cycles++;
        if (prev_stall) begin
          chk("hold_data", out_data, prev_data);
          chk("hold_tag", {60'd0, out_tag}, {60'd0, prev_tag});
        end
        prev_stall = 1'b1;
        prev_data  = out_data;
        prev_tag   = out_tag;
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && in_ready) begin
        got++;
        chk("order_tag", {60'd0, out_tag}, 64'(got));
        chk("order_data", out_data, exp_fp[got]);
        $display("[TB] stall seq pop tag=%0d out=%h cyc=%0d", out_tag, out_data, cyc);
      end
      if (in_valid && out_ready) next_op++;
    end
    @(negedge in_clk);
    in_valid = 1'b0;
    chk("stall_results", 64'(got), 64'd4);
    chk("stall_cycles", 64'(low_cycles), 64'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge in_clk);
      if (out_valid) extra++;
    end
    chk("stall_extra", 64'(extra), 64'd0);
  endtask

  task automatic reset_seq();
    int extra = 0;
    in_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge in_clk);
      in_valid           = 1'b1;
      in_data            = 64'(10 + i);
      in_fmt             = 1'b1;
      in_signed_unsigned = 1'b0;
      in_output_fmt      = 1'b1;
      in_rm              = 3'd0;
      in_tag             = TAG_WIDTH'(8 + i);
    end
    @(negedge in_clk);
    in_valid = 1'b0;
    chk("inflight_valid", {63'd0, out_valid}, 64'd1);
    in_rst_n = 1'b0;
    #1;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_tag", {60'd0, out_tag}, 64'd0);
    chk("rst_fflags", {59'd0, out_fflags}, 64'd0);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    #1;
    chk("rel_ready", {63'd0, out_ready}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge in_clk);
      if (out_valid) extra++;
    end
    chk("rst_no_results", 64'(extra), 64'd0);
    $display("[TB] reset seq: in-flight operands discarded, extra results=%0d", extra);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //           data                   fmt   uns   ofmt  rm    expected               nx
    vecs[0]  = '{64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 3'd0, 64'hBFF0_0000_0000_0000, 1'b0};
    vecs[1]  = '{64'hDEAD_BEEF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 3'd0, 64'hBFF0_0000_0000_0000, 1'b0};
    vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 3'd0, 64'h43F0_0000_0000_0000, 1'b1};
    vecs[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 3'd1, 64'h43EF_FFFF_FFFF_FFFF, 1'b1};
    vecs[4]  = '{64'h0000_0000_0100_0001, 1'b0, 1'b1, 1'b0, 3'd0, 64'hFFFF_FFFF_4B80_0000, 1'b1};
    vecs[5]  = '{64'h0000_0000_0100_0001, 1'b0, 1'b1, 1'b0, 3'd3, 64'hFFFF_FFFF_4B80_0001, 1'b1};
    vecs[6]  = '{64'h0000_0000_0100_0001, 1'b0, 1'b1, 1'b0, 3'd4, 64'hFFFF_FFFF_4B80_0001, 1'b1};
    vecs[7]  = '{64'h0000_0000_0100_0001, 1'b0, 1'b1, 1'b0, 3'd1, 64'hFFFF_FFFF_4B80_0000, 1'b1};
    vecs[8]  = '{64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 3'd0, 64'hC3E0_0000_0000_0000, 1'b0};
    vecs[9]  = '{64'h0000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 3'd0, 64'h0000_0000_0000_0000, 1'b0};
    vecs[10] = '{64'h1234_5678_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 3'd0, 64'h41EF_FFFF_FFE0_0000, 1'b0};
    vecs[11] = '{64'hFFDF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 3'd2, 64'hC340_0000_0000_0001, 1'b1};
    vecs[12] = '{64'hFFDF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 3'd3, 64'hC340_0000_0000_0000, 1'b1};
    vecs[13] = '{64'h0000_0000_8000_0000, 1'b0, 1'b0, 1'b0, 3'd0, 64'hFFFF_FFFF_CF00_0000, 1'b0};
    vecs[14] = '{64'h0000_0000_01FF_FFFF, 1'b0, 1'b1, 1'b0, 3'd0, 64'hFFFF_FFFF_4C00_0000, 1'b1};
    vecs[15] = '{64'h0000_0000_0100_0003, 1'b0, 1'b1, 1'b0, 3'd5, 64'hFFFF_FFFF_4B80_0002, 1'b1};

    in_rst_n           = 1'b0;
    in_valid           = 1'b0;
    in_ready           = 1'b1;
    in_data            = '0;
    in_fmt             = 1'b0;
    in_signed_unsigned = 1'b0;
    in_output_fmt      = 1'b0;
    in_rm              = 3'd0;
    in_tag             = '0;
    #3;
    chk("init_valid", {63'd0, out_valid}, 64'd0);
    chk("init_data", out_data, 64'd0);
    chk("init_tag", {60'd0, out_tag}, 64'd0);
    chk("init_fflags", {59'd0, out_fflags}, 64'd0);
    @(negedge in_clk);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    #1;
    chk("init_ready", {63'd0, out_ready}, 64'd1);

    for (int i = 0; i < NVEC; i++) begin
      run_vec(i, vecs[i]);
    end

    stall_seq();
    reset_seq();
    run_vec(3, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
